// File: rtl/hsem_lock_arb.sv
// hsem_lock_arb: round-robin lock/unlock arbiter for hardware semaphores.
// Optional HSEM_MASTER_CLR_EN adds a per-master forced release (clr_vld/clr_id).
module hsem_lock_arb #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2,
  parameter int NUM_SEM = 16,
  parameter int IDX_W   = 5,
  parameter int PID_W   = 8
) (
  input  logic                       hclk,
  input  logic                       hresetn,
`ifdef HSEM_MASTER_CLR_EN
  input  logic                       clr_vld,
  input  logic [REQ_W-1:0]           clr_id,
`endif
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*IDX_W-1:0]   req_idx,
  input  logic [NUM_REQ*PID_W-1:0]   req_pid,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic [NUM_REQ-1:0]         rsp_vld,
  output logic                       rsp_ok,
  output logic [NUM_SEM-1:0]         sem_locked,
  output logic [NUM_SEM*REQ_W-1:0]   sem_owner,
  output logic [NUM_SEM*PID_W-1:0]   sem_pid,
  output logic [NUM_SEM-1:0]         free_evt
);
  localparam int SEM_W = $clog2(NUM_SEM);
  logic [REQ_W-1:0]         rr_ptr, gnt_id;
  logic [NUM_REQ-1:0]       gnt;
  logic                     found, clr_on, acc, ok;
  logic                     cur_lock, in_range, cur_locked, match;
  logic [IDX_W-1:0]         cur_idx;
  logic [PID_W-1:0]         cur_pid;
  logic [SEM_W-1:0]         sidx;
  logic [NUM_SEM-1:0]       nxt_locked, nxt_evt;
  logic [NUM_SEM*REQ_W-1:0] nxt_owner;
  logic [NUM_SEM*PID_W-1:0] nxt_pid;
`ifdef HSEM_MASTER_CLR_EN
  assign clr_on = clr_vld;
`else
  assign clr_on = 1'b0;
`endif
  // First valid requester at or after rr_ptr; its fields are muxed out alongside the grant.
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    found = 1'b0;
    cur_lock = 1'b0;
    cur_idx = '0;
    cur_pid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_vld[j]) begin
        found = 1'b1;
        gnt[j] = 1'b1;
        gnt_id = REQ_W'(j);
        cur_lock = req_lock[j];
        cur_idx = req_idx[j*IDX_W +: IDX_W];
        cur_pid = req_pid[j*PID_W +: PID_W];
      end
    end
  end
  assign req_rdy    = clr_on ? '0 : gnt;
  assign acc        = |(req_vld & req_rdy);
  assign sidx       = cur_idx[SEM_W-1:0];
  assign in_range   = {1'b0, cur_idx} < (IDX_W+1)'(NUM_SEM);
  assign cur_locked = sem_locked[sidx];
  assign match      = cur_locked && sem_owner[sidx*REQ_W +: REQ_W] == gnt_id
                      && sem_pid[sidx*PID_W +: PID_W] == cur_pid;
  always_comb begin
    nxt_locked = sem_locked;
    nxt_owner = sem_owner;
    nxt_pid = sem_pid;
    nxt_evt = '0;
    ok = 1'b0;
    if (acc && in_range) begin
      ok = cur_lock ? (!cur_locked || match) : match;
      if (cur_lock && !cur_locked) begin
        nxt_locked[sidx] = 1'b1;
        nxt_owner[sidx*REQ_W +: REQ_W] = gnt_id;
        nxt_pid[sidx*PID_W +: PID_W] = cur_pid;
      end
      if (!cur_lock && match) begin
        nxt_locked[sidx] = 1'b0;
        nxt_owner[sidx*REQ_W +: REQ_W] = '0;
        nxt_pid[sidx*PID_W +: PID_W] = '0;
        nxt_evt[sidx] = 1'b1;
      end
    end
`ifdef HSEM_MASTER_CLR_EN
    for (int s = 0; s < NUM_SEM; s++) begin
      if (clr_vld && sem_locked[s] && sem_owner[s*REQ_W +: REQ_W] == clr_id) begin
        nxt_locked[s] = 1'b0;
        nxt_owner[s*REQ_W +: REQ_W] = '0;
        nxt_pid[s*PID_W +: PID_W] = '0;
        nxt_evt[s] = 1'b1;
      end
    end
`endif
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rr_ptr <= '0;
      sem_locked <= '0;
      sem_owner <= '0;
      sem_pid <= '0;
      free_evt <= '0;
      rsp_vld <= '0;
      rsp_ok <= 1'b0;
    end else begin
      sem_locked <= nxt_locked;
      sem_owner <= nxt_owner;
      sem_pid <= nxt_pid;
      free_evt <= nxt_evt;
      rsp_vld <= req_vld & req_rdy;
      rsp_ok <= acc & ok;
      if (acc) rr_ptr <= (gnt_id == REQ_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end
endmodule

// File: tb/tb_hsem_lock_arb.sv
// tb_hsem_lock_arb: directed table, fairness, reset and random checks against an array-based model.
module tb_hsem_lock_arb;
  logic         hclk = 1'b0;
  logic         hresetn = 1'b0;
  logic [3:0]   req_vld = '0, req_lock = '0;
  logic [19:0]  req_idx = '0;
  logic [31:0]  req_pid = '0;
  logic [3:0]   req_rdy, rsp_vld;
  logic         rsp_ok;
  logic [15:0]  sem_locked, free_evt;
  logic [31:0]  sem_owner;
  logic [127:0] sem_pid;
`ifdef HSEM_MASTER_CLR_EN
  logic         clr_vld = 1'b0;
  logic [1:0]   clr_id = '0;
`endif
  int errors = 0, checks = 0;
  int m_locked[16], m_owner[16], m_pid[16];
  int m_rr = 0, last_g = -1;

  hsem_lock_arb dut (
    .hclk(hclk), .hresetn(hresetn),
`ifdef HSEM_MASTER_CLR_EN
    .clr_vld(clr_vld), .clr_id(clr_id),
`endif
    .req_vld(req_vld), .req_lock(req_lock), .req_idx(req_idx), .req_pid(req_pid),
    .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_ok(rsp_ok), .sem_locked(sem_locked),
    .sem_owner(sem_owner), .sem_pid(sem_pid), .free_evt(free_evt)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [3:0]  vld, lock;
    logic [19:0] idx;
    logic [31:0] pid;
    logic [3:0]  e_rdy;
    logic        e_ok;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      m_locked[s] = 0; m_owner[s] = 0; m_pid[s] = 0;
    end
    m_rr = 0;
  endtask

  task automatic check_state(input string nm);
    logic [15:0] el;
    logic [31:0] eo;
    logic [127:0] ep;
    for (int s = 0; s < 16; s++) begin
      el[s] = m_locked[s][0];
      eo[s*2 +: 2] = m_owner[s][1:0];
      ep[s*8 +: 8] = m_pid[s][7:0];
    end
    chk({nm, ".locked"}, 128'(sem_locked), 128'(el));
    chk({nm, ".owner"}, 128'(sem_owner), 128'(eo));
    chk({nm, ".pid"}, sem_pid, ep);
  endtask

  // One clock: called just after a negedge with inputs already driven.
  task automatic tick(input string nm, input logic tbl_chk, input logic [3:0] e_rdy, input logic e_ok);
    int g, idx, pid;
    logic clr;
    logic [3:0] x_rdy;
    logic [15:0] x_evt;
    logic x_ok;
    clr = 1'b0;
`ifdef HSEM_MASTER_CLR_EN
    clr = clr_vld;
`endif
    #1;
    g = -1;
    if (!clr)
      for (int k = 0; k < 4; k++)
        if (g < 0 && req_vld[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    x_rdy = (g < 0) ? 4'b0 : 4'(1 << g);
    chk({nm, ".rdy"}, 128'(req_rdy), 128'(x_rdy));
    if (tbl_chk) chk({nm, ".rdy_tbl"}, 128'(req_rdy), 128'(e_rdy));
    x_evt = '0;
    x_ok = 1'b0;
    if (g >= 0) begin
      idx = int'(req_idx[g*5 +: 5]);
      pid = int'(req_pid[g*8 +: 8]);
      if (idx < 16) begin
        if (req_lock[g]) begin
          if (m_locked[idx] == 0) begin
            m_locked[idx] = 1; m_owner[idx] = g; m_pid[idx] = pid; x_ok = 1'b1;
          end else x_ok = (m_owner[idx] == g && m_pid[idx] == pid);
        end else if (m_locked[idx] == 1 && m_owner[idx] == g && m_pid[idx] == pid) begin
          m_locked[idx] = 0; m_owner[idx] = 0; m_pid[idx] = 0; x_ok = 1'b1; x_evt[idx] = 1'b1;
        end
      end
      m_rr = (g + 1) % 4;
    end
`ifdef HSEM_MASTER_CLR_EN
    if (clr)
      for (int s = 0; s < 16; s++)
        if (m_locked[s] == 1 && m_owner[s] == int'(clr_id)) begin
          m_locked[s] = 0; m_owner[s] = 0; m_pid[s] = 0; x_evt[s] = 1'b1;
        end
`endif
    last_g = g;
    @(posedge hclk);
    #1;
    chk({nm, ".rsp_vld"}, 128'(rsp_vld), 128'(x_rdy));
    chk({nm, ".rsp_ok"}, 128'(rsp_ok), 128'(x_ok));
    if (tbl_chk) chk({nm, ".ok_tbl"}, 128'(rsp_ok), 128'(e_ok));
    chk({nm, ".free_evt"}, 128'(free_evt), 128'(x_evt));
    check_state(nm);
    @(negedge hclk);
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3},  {8'h0, 8'h0, 8'h0, 8'h11},   4'b0001, 1'b1};
    tbl[1]  = '{4'b0001, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd3},  {8'h0, 8'h0, 8'h0, 8'h11},   4'b0001, 1'b1};
    tbl[2]  = '{4'b0000, 4'b0000, 20'd0,                     32'd0,                       4'b0000, 1'b0};
    tbl[3]  = '{4'b1000, 4'b0000, 20'd0,                     32'd0,                       4'b1000, 1'b0};
    tbl[4]  = '{4'b0110, 4'b0110, {5'd0, 5'd5, 5'd5, 5'd0},  {8'h0, 8'h33, 8'h22, 8'h0},  4'b0010, 1'b1};
    tbl[5]  = '{4'b0100, 4'b0100, {5'd0, 5'd5, 5'd5, 5'd0},  {8'h0, 8'h33, 8'h22, 8'h0},  4'b0100, 1'b0};
    tbl[6]  = '{4'b1100, 4'b1000, {5'd16, 5'd5, 5'd0, 5'd0}, {8'h0, 8'h33, 8'h0, 8'h0},   4'b1000, 1'b0};
    tbl[7]  = '{4'b0100, 4'b0000, {5'd0, 5'd5, 5'd0, 5'd0},  {8'h0, 8'h33, 8'h0, 8'h0},   4'b0100, 1'b0};
    tbl[8]  = '{4'b0010, 4'b0000, {5'd0, 5'd0, 5'd5, 5'd0},  {8'h0, 8'h0, 8'h23, 8'h0},   4'b0010, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0010, {5'd0, 5'd0, 5'd5, 5'd0},  {8'h0, 8'h0, 8'h22, 8'h0},   4'b0010, 1'b1};
    tbl[10] = '{4'b0010, 4'b0000, {5'd0, 5'd0, 5'd5, 5'd0},  {8'h0, 8'h0, 8'h22, 8'h0},   4'b0010, 1'b1};
    tbl[11] = '{4'b1000, 4'b1000, 20'd0,                     {8'h44, 8'h0, 8'h0, 8'h0},   4'b1000, 1'b1};
    model_reset();
    repeat (2) @(negedge hclk);
    chk("reset.rsp_vld", 128'(rsp_vld), 128'(0));
    chk("reset.rsp_ok", 128'(rsp_ok), 128'(0));
    chk("reset.free_evt", 128'(free_evt), 128'(0));
    check_state("reset");
    hresetn = 1'b1;
    @(negedge hclk);
    for (int i = 0; i < 12; i++) begin
      req_vld = tbl[i].vld; req_lock = tbl[i].lock; req_idx = tbl[i].idx; req_pid = tbl[i].pid;
      tick($sformatf("tbl%0d", i), 1'b1, tbl[i].e_rdy, tbl[i].e_ok);
    end
    // All four hold requests: strict rotation 0,1,2,3,0,...
    req_vld = 4'b1111; req_lock = 4'b1111;
    req_idx = {5'd11, 5'd10, 5'd9, 5'd8};
    req_pid = {8'd3, 8'd2, 8'd1, 8'd0};
    for (int i = 0; i < 8; i++) tick($sformatf("fair%0d", i), 1'b1, 4'(1 << (i % 4)), 1'b1);
    req_vld = '0;
`ifdef HSEM_MASTER_CLR_EN
    req_vld = 4'b1000; req_lock = 4'b1000; req_idx = {5'd1, 15'd0}; req_pid = {8'h55, 24'd0};
    tick("clr_lk1", 1'b1, 4'b1000, 1'b1);
    req_idx = {5'd9, 15'd0};
    tick("clr_lk9", 1'b1, 4'b1000, 1'b1);
    req_vld = 4'b0001; req_lock = 4'b0001; req_idx = 20'd2; req_pid = 32'h66;
    clr_vld = 1'b1; clr_id = 2'd3;
    tick("clr_go", 1'b1, 4'b0000, 1'b0);
    chk("clr_go.evt1", 128'(free_evt[1]), 128'(1));
    chk("clr_go.evt9", 128'(free_evt[9]), 128'(1));
    clr_vld = 1'b0;
    tick("clr_after", 1'b1, 4'b0001, 1'b1);
    req_vld = '0;
`endif
    // Reset asserted while a grant is pending: no response, all state cleared.
    req_vld = 4'b0001; req_lock = 4'b0001; req_idx = 20'd2; req_pid = 32'h5;
    #1;
    chk("rst_mid.rdy", 128'(req_rdy), 128'(4'b0001));
    hresetn = 1'b0;
    model_reset();
    @(posedge hclk);
    #1;
    chk("rst_mid.rsp_vld", 128'(rsp_vld), 128'(0));
    chk("rst_mid.free_evt", 128'(free_evt), 128'(0));
    check_state("rst_mid");
    @(negedge hclk);
    req_vld = '0;
    hresetn = 1'b1;
    @(negedge hclk);
    last_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!req_vld[r] || last_g == r) begin
          int v;
          v = int'($urandom_range(0, 5));
          req_vld[r] = 1'($urandom_range(0, 1));
          req_lock[r] = 1'($urandom_range(0, 1));
          req_idx[r*5 +: 5] = 5'((v < 4) ? v : v + 12);
          req_pid[r*8 +: 8] = 8'($urandom_range(0, 1));
        end
      end
`ifdef HSEM_MASTER_CLR_EN
      clr_vld = ($urandom_range(0, 7) == 0);
      clr_id = 2'($urandom_range(0, 3));
`endif
      tick("rand", 1'b0, 4'b0, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hsem_lock_arb.md
Name: hsem_lock_arb

Overview:
- Lock/arbitration core of the hardware semaphore block.
- Accepts lock and unlock requests from NUM_REQ requesters (CPU ports, or register-file decode per bus master).
- Grants one request per cycle using round-robin arbitration.
- Maintains per-semaphore lock state (locked, owner, process id), returns pass/fail, and pulses a per-semaphore free event on every successful release.

Parameters:
- NUM_REQ, 4, number of requesters.
- REQ_W, 2, requester id width (clog2 NUM_REQ).
- NUM_SEM, 16, number of semaphores.
- IDX_W, 5, semaphore index width (may exceed clog2 NUM_SEM).
- PID_W, 8, process id width.

Ports:
- hclk  in  1  clock; reset hresetn, asynchronous, active-low; clock hclk.
- hresetn  in  1  asynchronous active-low reset.
- req_vld  in  NUM_REQ  per-requester request valid; held until accepted.
- req_lock  in  NUM_REQ  1 = lock, 0 = unlock.
- req_idx  in  NUM_REQ*IDX_W  semaphore index, requester r at [r*IDX_W +: IDX_W].
- req_pid  in  NUM_REQ*PID_W  process id, packed the same way.
- req_rdy  out  NUM_REQ  one-hot grant; acceptance = req_vld[r] & req_rdy[r].
- rsp_vld  out  NUM_REQ  one-cycle response pulse to the accepted requester.
- rsp_ok  out  1  result qualifying rsp_vld; 1 = success.
- sem_locked  out  NUM_SEM  lock status per semaphore.
- sem_owner  out  NUM_SEM*REQ_W  owner id per semaphore.
- sem_pid  out  NUM_SEM*PID_W  owner pid per semaphore.
- free_evt  out  NUM_SEM  one-cycle pulse when a semaphore is released.

Behaviour:
- Reset values: all outputs 0, rr_ptr = 0, all semaphores free.
- Arbitration (combinational from req_vld and rr_ptr):
  - req_rdy grants the first valid requester at or after rr_ptr, searching upward modulo NUM_REQ.
  - At most one bit of req_rdy is set.
  - req_rdy is all-zero when no request is valid.
- rr_ptr update: on acceptance, rr_ptr <= granted+1 mod NUM_REQ. Otherwise unchanged.
- Latency: request accepted at edge N; sem_* state, rsp_vld, rsp_ok and free_evt all update at edge N (visible in cycle N+1). rsp_vld is a single-cycle pulse.
- Throughput: one request per cycle.
- Lock command:
  - idx >= NUM_SEM -> fail, no state change.
  - Semaphore free -> set locked, owner = r, pid = req_pid; ok = 1.
  - Locked with owner == r and pid == req_pid -> ok = 1, state unchanged (idempotent re-lock).
  - Otherwise -> ok = 0, state unchanged.
- Unlock command:
  - Locked with owner and pid both matching -> clear locked, owner and pid; ok = 1; free_evt[idx] pulses.
  - Free, mismatched owner/pid, or idx out of range -> ok = 0, no change, no free_evt.
- Back-to-back: a request accepted in cycle N+1 sees state as updated by the request accepted in cycle N.
- Unaccepted requesters keep req_vld high. There is no starvation: worst-case wait is NUM_REQ-1 cycles.
- Reset mid-operation: all state, pending responses and events are cleared; no rsp_vld is issued for the interrupted request.

Optional Feature:
- Macro: HSEM_MASTER_CLR_EN.
- Enabled:
  - Adds inputs clr_vld (1 bit) and clr_id (REQ_W bits).
  - When clr_vld = 1, every semaphore locked with owner == clr_id is freed at the next edge, with free_evt pulsed for each.
  - req_rdy is forced to 0 that cycle; the clear has priority and rr_ptr holds.
- Disabled: ports absent; no clear path.

Test Plan:
- Lock/unlock: req0 locks idx 3, pid 0x11 -> rsp_ok = 1, sem_locked[3] = 1, owner 0, pid 0x11. req0 unlocks idx 3, pid 0x11 -> ok = 1, free_evt[3] pulses one cycle, sem_locked[3] = 0.
- Contention: req1 and req2 both lock idx 5 in the same cycle with rr_ptr = 0 -> req1 granted with ok = 1; req2 granted next cycle with ok = 0; rr_ptr = 3 afterwards.
- Ownership check:
  - req1 holds idx 5 with pid 0x22.
  - req2 unlocks idx 5 -> ok = 0, still locked.
  - req1 unlocks with pid 0x23 -> ok = 0.
  - req1 re-locks with pid 0x22 -> ok = 1.
- Fairness: all four requesters hold req_vld for 8 cycles -> grants in order 0, 1, 2, 3, 0, 1, 2, 3; each rsp_vld fires exactly one cycle after its grant.
- Boundaries: lock idx 16 (NUM_SEM = 16) -> ok = 0, no state change. Unlock of a free idx 0 -> ok = 0, no free_evt. Assert hresetn mid-grant -> no rsp_vld, all sem_locked = 0.
- HSEM_MASTER_CLR_EN:
  - req3 holds idx 1 and idx 9.
  - clr_vld with clr_id = 3 while req0 is valid -> idx 1 and 9 freed, free_evt[1] and free_evt[9] pulse, req_rdy = 0 that cycle.
  - req0 is granted the following cycle.
